// File: rtl/clkdiv_pkg.sv
// Shared types and sizing helpers for the multi-channel clock divider.
package clkdiv_pkg;

  // Largest divisor any build of the divider is expected to support.
  localparam int MAX_DIV_LIMIT = 256;

  // Number of bits needed to hold a divisor value up to max_div inclusive.
  function automatic int div_w(input int max_div);
    return $clog2(max_div + 1);
  endfunction

  localparam int DIV_T_W = div_w(MAX_DIV_LIMIT);

  typedef logic [DIV_T_W-1:0] div_t;

  typedef enum logic {CH_IDLE, CH_RUN} ch_state_t;

endpackage

// File: rtl/clkdiv_channel.sv
// One divider channel: run/idle FSM, period counter, pending divisor register.
// Optional macro CLKDIV_ODD_DUTY_FIX_EN adds a negedge stage that stretches
// the high phase by half a clkin period on odd divisors (exact 50% duty).
module clkdiv_channel
  import clkdiv_pkg::*;
#(
  parameter int MAX_DIV     = 256,
  parameter int DEFAULT_DIV = 2,
  parameter int DIV_W       = 9
) (
  input  logic             clkin,
  input  logic             rst,
  input  logic             en,
  input  logic             div_load,
  input  logic [DIV_W-1:0] div_val,
  output logic             load_ack,
  output logic             load_err,
  output logic             tick,
  output logic             clkout
);

  localparam logic [DIV_W-1:0] MIN_V     = DIV_W'(2);
  localparam logic [DIV_W-1:0] MAX_V     = DIV_W'(MAX_DIV);
  localparam logic [DIV_W-1:0] DEFAULT_V = DIV_W'(DEFAULT_DIV);
  localparam logic [DIV_W-1:0] ONE_V     = DIV_W'(1);

  ch_state_t        state, state_nxt;
  logic [DIV_W-1:0] count, count_nxt;
  logic [DIV_W-1:0] div_q, div_nxt;
  logic [DIV_W-1:0] pend_q, pend_nxt;
  logic             pend_vld, pend_vld_nxt;
  logic             pos_hi, hi_nxt;
  logic             tick_q, tick_nxt;
  logic             ack_q, ack_nxt;
  logic             err_q, err_nxt;
  logic             legal, load_ok, wrap;

  // Next-state logic: divisor changes and run/idle changes only land on period boundaries.
  always_comb begin
    state_nxt    = state;
    count_nxt    = count;
    div_nxt      = div_q;
    pend_nxt     = pend_q;
    pend_vld_nxt = pend_vld;
    ack_nxt      = 1'b0;
    legal        = (div_val >= MIN_V) && (div_val <= MAX_V);
    load_ok      = div_load && legal;
    err_nxt      = div_load && !legal;
    wrap         = (count == (div_q - ONE_V));
    case (state)
      CH_IDLE: begin
        count_nxt = '0;
        if (pend_vld) begin
          div_nxt      = pend_q;
          pend_vld_nxt = 1'b0;
          ack_nxt      = 1'b1;
        end
        if (load_ok) begin
          div_nxt = div_val;
          ack_nxt = 1'b1;
        end
        if (en) begin
          state_nxt = CH_RUN;
        end
      end
      CH_RUN: begin
        if (wrap) begin
          count_nxt = '0;
          if (pend_vld) begin
            div_nxt      = pend_q;
            pend_vld_nxt = 1'b0;
            ack_nxt      = 1'b1;
          end
          if (!en) begin
            state_nxt = CH_IDLE;
          end
        end else begin
          count_nxt = count + ONE_V;
        end
        if (load_ok) begin
          pend_nxt     = div_val;
          pend_vld_nxt = 1'b1;
        end
      end
      default: begin
        state_nxt = CH_IDLE;
        count_nxt = '0;
      end
    endcase
    tick_nxt = (state_nxt == CH_RUN) && (count_nxt == '0);
    hi_nxt   = (state_nxt == CH_RUN) && (count_nxt < (div_nxt >> 1));
  end

  // State register with synchronous active-low reset; all outputs are registered here.
  always_ff @(posedge clkin) begin
    if (!rst) begin
      state    <= CH_IDLE;
      count    <= '0;
      div_q    <= DEFAULT_V;
      pend_q   <= '0;
      pend_vld <= 1'b0;
      pos_hi   <= 1'b0;
      tick_q   <= 1'b0;
      ack_q    <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state    <= state_nxt;
      count    <= count_nxt;
      div_q    <= div_nxt;
      pend_q   <= pend_nxt;
      pend_vld <= pend_vld_nxt;
      pos_hi   <= hi_nxt;
      tick_q   <= tick_nxt;
      ack_q    <= ack_nxt;
      err_q    <= err_nxt;
    end
  end

`ifdef CLKDIV_ODD_DUTY_FIX_EN
  logic neg_hi;

  // Half-cycle delayed copy of the high phase, used to stretch odd divisors to 50% duty.
  always_ff @(negedge clkin) begin
    if (!rst) begin
      neg_hi <= 1'b0;
    end else begin
      neg_hi <= pos_hi;
    end
  end

  assign clkout = pos_hi | (neg_hi & div_q[0]);
`else
  assign clkout = pos_hi;
`endif

  assign tick     = tick_q;
  assign load_ack = ack_q;
  assign load_err = err_q;

endmodule

// File: rtl/multi_channel_clk_divider.sv
// NUM_CH independent runtime-programmable clock dividers sharing clkin.
// Optional macro CLKDIV_ODD_DUTY_FIX_EN enables exact 50% duty on odd divisors.
module multi_channel_clk_divider
  import clkdiv_pkg::*;
#(
  parameter int NUM_CH      = 4,
  parameter int MAX_DIV     = 256,
  parameter int DEFAULT_DIV = 2,
  localparam int DIV_W      = div_w(MAX_DIV)
) (
  input  logic                    clkin,
  input  logic                    rst,
  input  logic [NUM_CH-1:0]       en,
  input  logic [NUM_CH-1:0]       div_load,
  input  logic [NUM_CH*DIV_W-1:0] div_val,
  output logic [NUM_CH-1:0]       load_ack,
  output logic [NUM_CH-1:0]       load_err,
  output logic [NUM_CH-1:0]       tick,
  output logic [NUM_CH-1:0]       clkout
);

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    clkdiv_channel #(
      .MAX_DIV     (MAX_DIV),
      .DEFAULT_DIV (DEFAULT_DIV),
      .DIV_W       (DIV_W)
    ) u_ch (
      .clkin    (clkin),
      .rst      (rst),
      .en       (en[i]),
      .div_load (div_load[i]),
      .div_val  (div_val[i*DIV_W +: DIV_W]),
      .load_ack (load_ack[i]),
      .load_err (load_err[i]),
      .tick     (tick[i]),
      .clkout   (clkout[i])
    );
  end

endmodule

// File: tb/tb_multi_channel_clk_divider.sv
// Self-checking bench for multi_channel_clk_divider: directed scenarios with
// literal expectations plus a randomized run checked against a behavioural model.
module tb_multi_channel_clk_divider;

  localparam int NUM_CH      = 4;
  localparam int MAX_DIV     = 256;
  localparam int DEFAULT_DIV = 2;
  localparam int DIV_W       = 9;

  logic                    clkin;
  logic                    rst;
  logic [NUM_CH-1:0]       en;
  logic [NUM_CH-1:0]       div_load;
  logic [NUM_CH*DIV_W-1:0] div_val;
  logic [NUM_CH-1:0]       load_ack;
  logic [NUM_CH-1:0]       load_err;
  logic [NUM_CH-1:0]       tick;
  logic [NUM_CH-1:0]       clkout;

  logic [DIV_W-1:0] stim_val [NUM_CH];
  logic [NUM_CH-1:0] en_reg;

  int total = 0;
  int bad   = 0;

  // behavioural model state: running flag, position in period, divisor, pending divisor
  int m_run  [NUM_CH];
  int m_k    [NUM_CH];
  int m_n    [NUM_CH];
  int m_pv   [NUM_CH];
  int m_pval [NUM_CH];
  int m_hi   [NUM_CH];
  int m_hip  [NUM_CH];
  logic [NUM_CH-1:0] e_tick, e_clk, e_ack, e_err;

  multi_channel_clk_divider #(
    .NUM_CH      (NUM_CH),
    .MAX_DIV     (MAX_DIV),
    .DEFAULT_DIV (DEFAULT_DIV)
  ) dut (
    .clkin    (clkin),
    .rst      (rst),
    .en       (en),
    .div_load (div_load),
    .div_val  (div_val),
    .load_ack (load_ack),
    .load_err (load_err),
    .tick     (tick),
    .clkout   (clkout)
  );

  initial begin
    clkin = 1'b0;
    forever #5 clkin = ~clkin;
  end

  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s at t=%0t: got=%0h expected=%0h", name, $time, got, exp);
    end
  endtask

  // one clkin edge with the given inputs; returns 2ns after that edge
  task automatic applyStimulus(input logic r, input logic [NUM_CH-1:0] e, input logic [NUM_CH-1:0] l);
    @(negedge clkin);
    rst      = r;
    en       = e;
    div_load = l;
    for (int c = 0; c < NUM_CH; c++) div_val[c*DIV_W +: DIV_W] = stim_val[c];
    @(posedge clkin);
    #2;
  endtask

  // advance the reference model by one clkin edge using the inputs seen at that edge
  task automatic modelStep();
    int v;
    bit legal;
    for (int c = 0; c < NUM_CH; c++) begin
      m_hip[c] = m_hi[c];
      e_ack[c] = 1'b0;
      e_err[c] = 1'b0;
      if (!rst) begin
        m_run[c] = 0; m_k[c] = 0; m_n[c] = DEFAULT_DIV; m_pv[c] = 0; m_pval[c] = 0;
      end else begin
        v = int'(div_val[c*DIV_W +: DIV_W]);
        legal = (v >= 2) && (v <= MAX_DIV);
        if (div_load[c] && !legal) e_err[c] = 1'b1;
        if (m_run[c] == 0) begin
          if (m_pv[c] != 0) begin m_n[c] = m_pval[c]; m_pv[c] = 0; e_ack[c] = 1'b1; end
          if (div_load[c] && legal) begin m_n[c] = v; e_ack[c] = 1'b1; end
          m_k[c] = 0;
          if (en[c]) m_run[c] = 1;
        end else begin
          if (m_k[c] == m_n[c] - 1) begin
            m_k[c] = 0;
            if (m_pv[c] != 0) begin m_n[c] = m_pval[c]; m_pv[c] = 0; e_ack[c] = 1'b1; end
            if (!en[c]) m_run[c] = 0;
          end else begin
            m_k[c] = m_k[c] + 1;
          end
          if (div_load[c] && legal) begin m_pval[c] = v; m_pv[c] = 1; end
        end
      end
      e_tick[c] = (m_run[c] != 0) && (m_k[c] == 0);
      m_hi[c]   = ((m_run[c] != 0) && (m_k[c] < m_n[c] / 2)) ? 1 : 0;
`ifdef CLKDIV_ODD_DUTY_FIX_EN
      e_clk[c]  = (m_hi[c] != 0) || ((m_n[c] % 2 == 1) && (m_hip[c] != 0));
`else
      e_clk[c]  = (m_hi[c] != 0);
`endif
    end
  endtask

  // compare process: model update at each edge, DUT outputs checked 1ns later
  always @(posedge clkin) begin
    modelStep();
    #1;
    checkOutput("model_tick", 32'(tick), 32'(e_tick));
    checkOutput("model_clkout", 32'(clkout), 32'(e_clk));
    checkOutput("model_load_ack", 32'(load_ack), 32'(e_ack));
    checkOutput("model_load_err", 32'(load_err), 32'(e_err));
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int hi_cnt, tick_cnt, ack_cnt, n;
    bit seen;
    for (int c = 0; c < NUM_CH; c++) begin
      m_run[c] = 0; m_k[c] = 0; m_n[c] = DEFAULT_DIV; m_pv[c] = 0; m_pval[c] = 0;
      m_hi[c] = 0; m_hip[c] = 0;
      stim_val[c] = '0;
    end
    rst = 1'b0; en = '0; div_load = '0; div_val = '0;

    // reset held with en=1: everything stays quiet
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 4'hF, 4'h0);
      checkOutput("reset_outputs", 32'({load_ack, load_err, tick, clkout}), 32'h0);
    end

    // ch0 at default N=2: tick and clkout toggle 1,0,1,0
    en_reg = 4'b0001;
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, en_reg, 4'h0);
      checkOutput("ch0_n2_tick", 32'(tick[0]), (i % 2 == 0) ? 32'd1 : 32'd0);
      checkOutput("ch0_n2_clk", 32'(clkout[0]), (i % 2 == 0) ? 32'd1 : 32'd0);
    end

    // ch1 load 9 while idle together with enable
    en_reg = 4'b0011;
    stim_val[1] = 9'd9;
    applyStimulus(1'b1, en_reg, 4'b0010);
    checkOutput("ch1_load_ack", 32'(load_ack[1]), 32'd1);
    hi_cnt = int'(clkout[1]);
    tick_cnt = 0;
    for (int i = 1; i <= 8; i++) begin
      applyStimulus(1'b1, en_reg, 4'h0);
      hi_cnt += int'(clkout[1]);
      tick_cnt += int'(tick[1]);
    end
    checkOutput("ch1_no_tick_mid", 32'(tick_cnt), 32'd0);
`ifdef CLKDIV_ODD_DUTY_FIX_EN
    checkOutput("ch1_high_samples", 32'(hi_cnt), 32'd5);
`else
    checkOutput("ch1_high_cycles", 32'(hi_cnt), 32'd4);
`endif
    applyStimulus(1'b1, en_reg, 4'h0);
    checkOutput("ch1_tick_at_9", 32'(tick[1]), 32'd1);

    // ch2 at N=4, two loads in one period: single ack at next tick, then period 10
    en_reg = 4'b0111;
    stim_val[2] = 9'd4;
    applyStimulus(1'b1, en_reg, 4'b0100);
    checkOutput("ch2_start_ack", 32'(load_ack[2]), 32'd1);
    ack_cnt = 0;
    stim_val[2] = 9'd6;
    applyStimulus(1'b1, en_reg, 4'b0100);
    ack_cnt += int'(load_ack[2]);
    stim_val[2] = 9'd10;
    applyStimulus(1'b1, en_reg, 4'b0100);
    ack_cnt += int'(load_ack[2]);
    applyStimulus(1'b1, en_reg, 4'h0);
    ack_cnt += int'(load_ack[2]);
    checkOutput("ch2_no_early_ack", 32'(ack_cnt), 32'd0);
    applyStimulus(1'b1, en_reg, 4'h0);
    checkOutput("ch2_ack_at_tick", 32'({load_ack[2], tick[2]}), 32'h3);
    n = 0; seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      applyStimulus(1'b1, en_reg, 4'h0);
      n++;
      seen = tick[2];
    end
    checkOutput("ch2_period_10", 32'(n), 32'd10);

    // ch3 at N=8: drop en at k=2, full period completes then idles
    stim_val[3] = 9'd8;
    applyStimulus(1'b1, 4'b1111, 4'b1000);
    hi_cnt = int'(clkout[3]);
    for (int i = 1; i <= 7; i++) begin
      applyStimulus(1'b1, (i >= 2) ? 4'b0111 : 4'b1111, 4'h0);
      hi_cnt += int'(clkout[3]);
    end
    checkOutput("ch3_high_4", 32'(hi_cnt), 32'd4);
    tick_cnt = 0;
    for (int i = 0; i < 11; i++) begin
      applyStimulus(1'b1, 4'b0111, 4'h0);
      tick_cnt += int'(tick[3]) + int'(clkout[3]);
    end
    checkOutput("ch3_idle_quiet", 32'(tick_cnt), 32'd0);

    // ch3 drop en at k=2 and re-assert at k=5: next period follows with no gap
    applyStimulus(1'b1, 4'b1111, 4'h0);
    for (int i = 1; i <= 8; i++) begin
      applyStimulus(1'b1, (i >= 2 && i <= 4) ? 4'b0111 : 4'b1111, 4'h0);
    end
    checkOutput("ch3_seamless_tick", 32'(tick[3]), 32'd1);
    en_reg = 4'b1111;

    // illegal loads on ch0 (running N=2): error pulse only
    for (int j = 0; j < 3; j++) begin
      stim_val[0] = (j == 0) ? 9'd0 : (j == 1) ? 9'd1 : 9'd257;
      applyStimulus(1'b1, en_reg, 4'b0001);
      checkOutput("ch0_err_pulse", 32'({load_err[0], load_ack[0]}), 32'h2);
      applyStimulus(1'b1, en_reg, 4'h0);
      checkOutput("ch0_err_clear", 32'(load_err[0]), 32'd0);
    end

    // load MAX_DIV on ch0: accepted, period becomes 256
    stim_val[0] = 9'd256;
    applyStimulus(1'b1, en_reg, 4'b0001);
    seen = load_ack[0];
    for (int i = 0; i < 4 && !seen; i++) begin
      applyStimulus(1'b1, en_reg, 4'h0);
      seen = load_ack[0];
    end
    checkOutput("ch0_maxdiv_ack", 32'(seen), 32'd1);
    n = 0; seen = 1'b0;
    for (int i = 0; i < 600 && !seen; i++) begin
      applyStimulus(1'b1, en_reg, 4'h0);
      n++;
      seen = tick[0];
    end
    checkOutput("ch0_period_256", 32'(n), 32'd256);

    // reset mid-high at k=3 of N=8 on ch3 with a pending load
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      applyStimulus(1'b1, en_reg, 4'h0);
      seen = tick[3];
    end
    checkOutput("ch3_found_tick", 32'(seen), 32'd1);
    stim_val[3] = 9'd5;
    applyStimulus(1'b1, en_reg, 4'b1000);
    applyStimulus(1'b1, en_reg, 4'h0);
    applyStimulus(1'b1, en_reg, 4'h0);
    checkOutput("ch3_high_k3", 32'(clkout[3]), 32'd1);
    applyStimulus(1'b0, en_reg, 4'h0);
    checkOutput("midrst_outputs", 32'({load_ack, load_err, tick, clkout}), 32'h0);
    en_reg = 4'b1000;
    applyStimulus(1'b1, en_reg, 4'h0);
    checkOutput("post_rst_k0", 32'({load_ack[3], tick[3], clkout[3]}), 32'h3);
    applyStimulus(1'b1, en_reg, 4'h0);
    checkOutput("post_rst_k1", 32'({tick[3], clkout[3]}), 32'h0);
    applyStimulus(1'b1, en_reg, 4'h0);
    checkOutput("post_rst_n2", 32'({load_ack[3], tick[3]}), 32'h1);

    // randomized traffic checked by the compare process
    for (int cyc = 0; cyc < 3000; cyc++) begin
      logic [NUM_CH-1:0] l;
      logic r;
      int sel;
      l = '0;
      r = ($urandom_range(0, 499) != 0);
      for (int c = 0; c < NUM_CH; c++) begin
        if ($urandom_range(0, 19) == 0) en_reg[c] = ~en_reg[c];
        if ($urandom_range(0, 14) == 0) begin
          l[c] = 1'b1;
          sel = $urandom_range(0, 19);
          case (sel)
            0: stim_val[c] = 9'd0;
            1: stim_val[c] = 9'd1;
            2: stim_val[c] = 9'd257;
            3: stim_val[c] = 9'($urandom_range(258, 511));
            4: stim_val[c] = 9'd256;
            default: stim_val[c] = 9'($urandom_range(2, 12));
          endcase
        end
      end
      applyStimulus(r, en_reg, l);
    end

    @(negedge clkin);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
